// File: rtl/sigout_checker.sv
// Purpose : sink-side pattern checker; symbol i of each decoded frame must equal (i+1) mod 2^W.
// Latency : frame_done pulses the cycle after the K-th symbol is accepted; stats settle one edge later.
// Backpr. : in_ready is high except during the single REPORT cycle that closes each frame.
//
// Ports:
//   clk, clrn      - clock (rising edge) and asynchronous active-low reset
//   in_valid/in_sof/in_data/in_ready - symbol stream from the RS decoder; in_sof marks index 0
//   clr_stats      - synchronous clear of frame_cnt, bad_frame_cnt, proto_err
//   frame_done     - one-cycle pulse while the completed frame is being reported
//   frame_ok/mism_cnt - result of the last completed frame, held until the next one
//   frame_cnt/bad_frame_cnt - running frame statistics (wrapping)
//   proto_err      - sticky framing-violation flag
module sigout_checker #(
    parameter int K = 239,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         clr_stats,
    output logic         frame_done,
    output logic         frame_ok,
    output logic [7:0]   mism_cnt,
    output logic [15:0]  frame_cnt,
    output logic [15:0]  bad_frame_cnt,
    output logic         proto_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Index of the last symbol in a frame; idx is W bits because K never exceeds 2^W-1.
    localparam logic [W-1:0] LAST = W'(K - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [7:0]   run_q, run_d;

    logic         accept;
    logic         start;
    logic [W-1:0] exp_sym;
    logic         miss;
    logic [7:0]   run_base;
    logic [7:0]   run_next;
    logic         proto_set;

    // Datapath for the symbol being accepted this cycle. A symbol carrying in_sof
    // always restarts the pattern, both from IDLE and mid-frame.
    always_comb begin
        accept   = in_valid && in_ready;
        start    = accept && in_sof;
        exp_sym  = start ? ONE : (idx_q + ONE);
        miss     = (in_data != exp_sym);
        run_base = start ? 8'd0 : run_q;
        // Saturating add: once at 255 the count sticks there.
        if (run_base == 8'hFF) begin
            run_next = 8'hFF;
        end else begin
            run_next = run_base + {7'd0, miss};
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        run_d      = run_q;
        proto_set  = 1'b0;
        in_ready   = (state_q != REPORT);
        frame_done = (state_q == REPORT);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        idx_d   = ONE;
                        run_d   = run_next;
                        state_d = (K == 1) ? REPORT : RECV;
                    end else begin
                        // Data outside a frame is dropped and flagged.
                        proto_set = 1'b1;
                    end
                end
            end

            RECV: begin
                if (accept) begin
                    run_d = run_next;
                    if (in_sof) begin
                        // Partial frame is abandoned; this symbol is index 0 of a new one.
                        proto_set = 1'b1;
                        idx_d     = ONE;
                        state_d   = (K == 1) ? REPORT : RECV;
                    end else if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = REPORT;
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end
            end

            REPORT: begin
                idx_d   = '0;
                run_d   = 8'd0;
                state_d = IDLE;
            end

            default: begin
                idx_d   = '0;
                run_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Frame-tracking state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            run_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
        end
    end

    // Per-frame result registers: only REPORT touches them, clr_stats does not.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mism_cnt <= 8'd0;
            frame_ok <= 1'b0;
        end else if (state_q == REPORT) begin
            mism_cnt <= run_q;
            frame_ok <= (run_q == 8'd0);
        end
    end

    // Running statistics. clr_stats has priority, so a frame completing on the
    // same edge as the clear is deliberately not counted.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            frame_cnt     <= 16'd0;
            bad_frame_cnt <= 16'd0;
            proto_err     <= 1'b0;
        end else if (clr_stats) begin
            frame_cnt     <= 16'd0;
            bad_frame_cnt <= 16'd0;
            proto_err     <= 1'b0;
        end else begin
            if (state_q == REPORT) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (run_q != 8'd0) begin
                    bad_frame_cnt <= bad_frame_cnt + 16'd1;
                end
            end
            if (proto_set) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sigout_checker.sv
// Purpose : directed bench for sigout_checker (K=239/W=8 main instance, K=300/W=9 saturation instance).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there or on the falling edge.
// Backpr. : symbols are only offered outside REPORT, so every offered symbol is accepted.
module tb_sigout_checker;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        clr_stats = 1'b0;
    logic        frame_done;
    logic        frame_ok;
    logic [7:0]  mism_cnt;
    logic [15:0] frame_cnt;
    logic [15:0] bad_frame_cnt;
    logic        proto_err;

    logic        s_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic [8:0]  s_data = 9'd0;
    logic        s_ready;
    logic        s_clr = 1'b0;
    logic        s_done;
    logic        s_ok;
    logic [7:0]  s_mism;
    logic [15:0] s_fcnt;
    logic [15:0] s_bad;
    logic        s_perr;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int rdy_low_seen = 0;

    always #5 clk = ~clk;

    sigout_checker #(.K(239), .W(8)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .in_ready(in_ready), .clr_stats(clr_stats), .frame_done(frame_done), .frame_ok(frame_ok),
        .mism_cnt(mism_cnt), .frame_cnt(frame_cnt), .bad_frame_cnt(bad_frame_cnt),
        .proto_err(proto_err)
    );

    sigout_checker #(.K(300), .W(9)) dut_s (
        .clk(clk), .clrn(clrn), .in_valid(s_valid), .in_sof(s_sof), .in_data(s_data),
        .in_ready(s_ready), .clr_stats(s_clr), .frame_done(s_done), .frame_ok(s_ok),
        .mism_cnt(s_mism), .frame_cnt(s_fcnt), .bad_frame_cnt(s_bad), .proto_err(s_perr)
    );

    // Count frame_done pulses and in_ready-low cycles of the main instance.
    always @(negedge clk) begin
        if (frame_done) done_seen++;
        if (!in_ready) rdy_low_seen++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [7:0] d, input logic sof, input int gap);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    // kind 0: clean, 1: symbols 5 and 100 XOR 0x01, 2: all zero.
    function automatic logic [7:0] sym_val(input int kind, input int i);
        logic [7:0] v;
        v = 8'(i + 1);
        if (kind == 1 && (i == 4 || i == 99)) v = v ^ 8'h01;
        if (kind == 2) v = 8'h00;
        return v;
    endfunction

    // Leaves the bench 1 unit after the edge that accepted the last symbol (REPORT cycle).
    task automatic send_frame(input int kind, input int gap);
        for (int i = 0; i < 239; i++) begin
            send_sym(sym_val(kind, i), (i == 0), (i == 238) ? 0 : gap);
        end
    endtask

    typedef struct {
        int kind;
        int gap;
        int e_mism;
        int e_ok;
        int e_fcnt;
        int e_bad;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int d0, r0;

        vecs[0] = '{kind: 0, gap: 0, e_mism: 0,   e_ok: 1, e_fcnt: 1, e_bad: 0};
        vecs[1] = '{kind: 1, gap: 1, e_mism: 2,   e_ok: 0, e_fcnt: 2, e_bad: 1};
        vecs[2] = '{kind: 2, gap: 0, e_mism: 239, e_ok: 0, e_fcnt: 3, e_bad: 2};
        vecs[3] = '{kind: 0, gap: 2, e_mism: 0,   e_ok: 1, e_fcnt: 4, e_bad: 2};

        // Reset state.
        #3;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_ok", int'(frame_ok), 0);
        chk("rst_mism_cnt", int'(mism_cnt), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_bad_cnt", int'(bad_frame_cnt), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        clrn = 1'b1;
        tick();
        tick();

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            d0 = done_seen;
            r0 = rdy_low_seen;
            send_frame(vecs[v].kind, vecs[v].gap);
            chk($sformatf("v%0d_done_pulse", v), int'(frame_done), 1);
            tick();
            chk($sformatf("v%0d_done_after", v), int'(frame_done), 0);
            chk($sformatf("v%0d_done_count", v), done_seen - d0, 1);
            chk($sformatf("v%0d_rdy_low_cycles", v), rdy_low_seen - r0, 1);
            chk($sformatf("v%0d_mism_cnt", v), int'(mism_cnt), vecs[v].e_mism);
            chk($sformatf("v%0d_frame_ok", v), int'(frame_ok), vecs[v].e_ok);
            chk($sformatf("v%0d_frame_cnt", v), int'(frame_cnt), vecs[v].e_fcnt);
            chk($sformatf("v%0d_bad_cnt", v), int'(bad_frame_cnt), vecs[v].e_bad);
            chk($sformatf("v%0d_proto_err", v), int'(proto_err), 0);
        end

        // clr_stats coincident with REPORT: clear wins, frame results still update.
        send_sym(8'd1, 1'b0, 1);
        chk("clr_pre_proto_err", int'(proto_err), 1);
        chk("clr_stray_not_counted", int'(frame_cnt), 4);
        send_frame(2, 0);
        chk("clr_done_pulse", int'(frame_done), 1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_frame_cnt", int'(frame_cnt), 0);
        chk("clr_bad_cnt", int'(bad_frame_cnt), 0);
        chk("clr_proto_err", int'(proto_err), 0);
        chk("clr_mism_cnt", int'(mism_cnt), 239);
        chk("clr_frame_ok", int'(frame_ok), 0);

        // Stray symbol in IDLE, then in_sof at index 50 restarts the frame.
        send_sym(8'd7, 1'b0, 0);
        chk("proto_stray_flag", int'(proto_err), 1);
        d0 = done_seen;
        for (int i = 0; i < 50; i++) send_sym(sym_val(0, i), (i == 0), 0);
        for (int i = 0; i < 239; i++) send_sym(sym_val(0, i), (i == 0), 0);
        chk("proto_done_pulse", int'(frame_done), 1);
        tick();
        chk("proto_done_count", done_seen - d0, 1);
        chk("proto_frame_cnt", int'(frame_cnt), 1);
        chk("proto_bad_cnt", int'(bad_frame_cnt), 0);
        chk("proto_frame_ok", int'(frame_ok), 1);
        chk("proto_mism_cnt", int'(mism_cnt), 0);
        chk("proto_err_sticky", int'(proto_err), 1);

        // Reset asserted at index 120 of a frame.
        for (int i = 0; i < 120; i++) send_sym(sym_val(1, i), (i == 0), 0);
        clrn = 1'b0;
        #2;
        chk("mrst_in_ready", int'(in_ready), 1);
        chk("mrst_frame_done", int'(frame_done), 0);
        chk("mrst_frame_ok", int'(frame_ok), 0);
        chk("mrst_mism_cnt", int'(mism_cnt), 0);
        chk("mrst_frame_cnt", int'(frame_cnt), 0);
        chk("mrst_proto_err", int'(proto_err), 0);
        clrn = 1'b1;
        tick();
        d0 = done_seen;
        send_frame(0, 0);
        chk("mrst_done_pulse", int'(frame_done), 1);
        tick();
        chk("mrst_done_count", done_seen - d0, 1);
        chk("mrst_after_frame_cnt", int'(frame_cnt), 1);
        chk("mrst_after_frame_ok", int'(frame_ok), 1);
        chk("mrst_after_proto_err", int'(proto_err), 0);

        // Saturation: 300 wrong symbols on the K=300/W=9 instance.
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'b1;
            s_sof   = (i == 0);
            s_data  = 9'd0;
            tick();
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk("sat_done_pulse", int'(s_done), 1);
        tick();
        chk("sat_mism_cnt", int'(s_mism), 255);
        chk("sat_frame_ok", int'(s_ok), 0);
        chk("sat_frame_cnt", int'(s_fcnt), 1);
        chk("sat_bad_cnt", int'(s_bad), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sigout_checker.md
Name: sigout_checker

Overview:
- Sink-side counterpart of the encoder's sample data source.
- Sits at the RS decoder output and consumes the corrected message symbols of each frame.
- Checks every symbol against the known source pattern: symbol at in-frame index i must equal (i+1) mod 2^W.
- Reports per-frame pass/fail and mismatch count, and keeps running frame and bad-frame statistics for bench and silicon self-test.

Parameters:
- K, 239, message symbols per frame (decoded data part); legal range 1..2^W-1.
- W, 8, symbol width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- clrn  input  1  asynchronous, active-low reset.
- in_valid  input  1  a symbol is presented on in_data.
- in_sof  input  1  qualifies in_valid: the presented symbol is index 0 of a frame.
- in_data  input  W  decoded symbol.
- in_ready  output  1  the checker can accept a symbol this cycle.
- clr_stats  input  1  synchronous clear of frame_cnt, bad_frame_cnt and proto_err.
- frame_done  output  1  one-cycle pulse when a complete frame has been checked.
- frame_ok  output  1  last completed frame had zero mismatches; held until the next frame_done.
- mism_cnt  output  8  mismatches in the last completed frame; saturates at 255; held until the next frame_done.
- frame_cnt  output  16  completed frames since reset or clear; wraps at 65535 -> 0.
- bad_frame_cnt  output  16  completed frames with mism_cnt != 0; wraps.
- proto_err  output  1  sticky framing-violation flag.

Behaviour:
- Reset (clrn low, asynchronous):
  - state = IDLE, idx = 0, running mismatch count = 0.
  - in_ready = 1, frame_done = 0, frame_ok = 0, mism_cnt = 0, frame_cnt = 0, bad_frame_cnt = 0, proto_err = 0.
- Handshake:
  - A symbol is accepted when in_valid & in_ready on a rising edge.
  - in_valid may drop between symbols; gaps are unbounded and do not affect checking.
- States:
  - IDLE: in_ready = 1.
    - Accepted symbol with in_sof = 1: compare against 1, set idx = 1, go to RECV (or to REPORT if K = 1).
    - Accepted symbol with in_sof = 0: dropped, proto_err set, stay in IDLE.
  - RECV: in_ready = 1.
    - Accepted symbol with in_sof = 0: compare against (idx+1) mod 2^W, increment idx.
    - When the K-th symbol is accepted (idx = K-1 before the increment), go to REPORT.
    - Accepted symbol with in_sof = 1 mid-frame: proto_err set; the partial frame is discarded and not counted; this symbol becomes index 0 of a new frame (compare against 1, idx = 1).
  - REPORT: exactly one cycle.
    - in_ready = 0, frame_done = 1.
    - mism_cnt and frame_ok load from the running count; frame_cnt increments; bad_frame_cnt increments if the count is nonzero.
    - Running count and idx clear; next state is IDLE.
- Latency: frame_done is asserted on the cycle after the last symbol of the frame is accepted.
- Mismatch: in_data != expected[W-1:0]. The running count saturates at 255 and never wraps.
- clr_stats:
  - Clears frame_cnt, bad_frame_cnt and proto_err on the next edge.
  - Does not disturb an in-progress frame, mism_cnt or frame_ok.
  - Coincident with REPORT: the clear wins; the counters read 0 after that edge and the completing frame is not counted. frame_done, mism_cnt and frame_ok still update.
- Reset asserted mid-frame: the partial frame is lost; the next frame must begin with in_sof.

Test Plan:
- Reset, then one clean frame of K = 239 symbols 1..239 with in_sof on the first -> one frame_done pulse the cycle after symbol 239; frame_ok = 1, mism_cnt = 0, frame_cnt = 1, bad_frame_cnt = 0, proto_err = 0.
- Frame with symbols 5 and 100 flipped (XOR 0x01), in_valid toggled every other cycle -> mism_cnt = 2, frame_ok = 0, bad_frame_cnt = 1; in_ready low only in the REPORT cycle.
- Frame of all 0x00 -> mism_cnt = 239, frame_ok = 0. With K = 255 and all symbols wrong -> mism_cnt = 255 (saturated).
- Symbol without in_sof in IDLE, then in_sof at index 50 of a frame -> proto_err = 1; the aborted frame is not counted; the restarted 239-symbol frame passes with frame_cnt = 1.
- clr_stats asserted on the REPORT cycle after 3 frames -> frame_cnt = 0, bad_frame_cnt = 0, proto_err = 0; frame_done still pulses.
- clrn pulsed low at index 120 -> all outputs at reset values; the following clean frame passes with frame_cnt = 1.
